hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Stall/flush generator for the 5-stage pipeline, covering the hazards the forwarding path cannot resolve.
- Detects load-use hazards in ID, freezes the pipe while a data-memory load is outstanding, and squashes wrong-path instructions after a taken branch/jump resolved in EX.
- Sits beside the forwarding logic. Its outputs drive the enables of the PC and IF/ID/EX/MEM pipeline registers and the bubble-insert/flush controls.

Parameters:
- FLUSH_CYCLES, 2: cycles flush_id stays asserted after a redirect, covering in-flight instruction fetches; legal range 1..15.
- MEM_TIMEOUT, 15: maximum consecutive MEM_WAIT cycles before mem_timeout fires; legal range 1..255.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-low reset
- rs_1_id  in  5  ID-stage source register 1
- rs_2_id  in  5  ID-stage source register 2
- rs_1_used  in  1  ID instruction reads rs_1
- rs_2_used  in  1  ID instruction reads rs_2
- control_ex  in  control_t  EX-stage control; uses write_back_id and mem_read
- branch_taken_ex  in  1  EX resolved a taken branch/jump this cycle
- mem_req  in  1  MEM stage issues a load request this cycle
- mem_ready  in  1  data memory returns load data this cycle
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID register
- freeze_all  out  1  hold ID/EX, EX/MEM and MEM/WB registers
- flush_id  out  1  clear IF/ID to NOP
- flush_ex  out  1  clear ID/EX to NOP (bubble)
- mem_timeout  out  1  sticky error: load exceeded MEM_TIMEOUT

Behaviour:
- Reset (rst=0, async): state=RUN, counters=0, mem_timeout=0. All outputs 0 while in reset.
- States: RUN, MEM_WAIT, FLUSH. Outputs are combinational from state and current inputs; only state and counters are registered.
- Load-use (evaluated in RUN only):
  - Condition: control_ex.mem_read=1, control_ex.write_back_id!=0, and (rs_1_used with rs_1_id match, or rs_2_used with rs_2_id match).
  - Response: stall_pc=stall_if_id=flush_ex=1 for exactly that cycle. No state change.
  - Repeats naturally if the next cycle is also a hazard (it cannot be, because the bubble clears EX).
- x0 (id 0) never creates a hazard.
- Priority, highest first: MEM_WAIT, then branch flush, then load-use. On a branch, load-use is suppressed because the ID instruction is being squashed.
- RUN→MEM_WAIT: mem_req=1 and mem_ready=0 in the same cycle. A same-cycle mem_ready (zero-wait load) stays in RUN.
- MEM_WAIT:
  - stall_pc=stall_if_id=freeze_all=1; flush outputs 0.
  - branch_taken_ex is ignored because EX is frozen; the branch is re-seen on exit.
  - wait_cnt increments each cycle. On mem_ready=1 go to RUN; outputs are still stalled in that cycle, and the pipe moves on the next edge.
  - wait_cnt reaching MEM_TIMEOUT sets mem_timeout (sticky until reset) and forces the return to RUN.
- RUN→FLUSH: branch_taken_ex=1 while not entering MEM_WAIT.
  - In the detect cycle: flush_id=flush_ex=1.
  - Then flush_id=1 for FLUSH_CYCLES further cycles; flush_cnt decrements from FLUSH_CYCLES; at 0 go to RUN.
- FLUSH:
  - Load-use is ignored.
  - A new branch_taken_ex restarts flush_cnt (wrong-path branches are already squashed, so this occurs only on a redirect chain).
  - mem_req without same-cycle mem_ready goes to MEM_WAIT; the remaining flush count is retained and resumed afterwards.
- Counters saturate; none wrap.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN adds 32-bit output ports perf_load_use_cnt, perf_mem_wait_cnt and perf_flush_cnt.
  - Each counts cycles with the respective condition active.
  - Each saturates at 0xFFFF_FFFF and resets to 0.
- Without the macro these ports and counters do not exist, and the core behaviour is identical.

Decomposition:
- common_pkg: add a mem_read field to control_t and hazard_state_t (RUN/MEM_WAIT/FLUSH). It also gets constants REG_ZERO=5'd0, HAZ_FLUSH_CYCLES_DEF=2 and HAZ_MEM_TIMEOUT_DEF=15.
- One natural sub-module, load_use_detect: purely combinational comparator for the register match. All sequencing stays in hazard_unit.

Test Plan:
- Load-use: EX holds lw with write_back_id=5, mem_read=1; ID has rs_1_id=5, rs_1_used=1 → one cycle of stall_pc=stall_if_id=flush_ex=1, then all 0. Repeating with write_back_id=0 → no stall.
- Unused operand: rs_2_id=5, rs_2_used=0, same EX load → no stall.
- Memory wait: mem_req=1 with mem_ready low 3 cycles, high in the 4th → freeze_all=1 for 4 cycles, state RUN afterwards, mem_timeout=0. Holding mem_ready low for 15 cycles → mem_timeout=1 and stays 1.
- Branch: branch_taken_ex pulse with FLUSH_CYCLES=2 → flush_ex=1 for 1 cycle, flush_id=1 for 3 cycles. A load-use hazard presented during those cycles → no stall.
- Priority: branch_taken_ex and unmatched mem_req asserted together → MEM_WAIT first, no flush. After mem_ready, a re-presented branch → flush sequence.
- Async reset: assert rst=0 mid-MEM_WAIT between clock edges → all outputs 0 immediately. After release, behaviour starts in RUN.

Source files
------------

// File: rtl/common_pkg.sv
// -----------------------------------------------------------------------------
// common_pkg
// Shared types and constants for the pipeline hazard logic.
//   control_t       : EX-stage control bundle (destination register, load flag)
//   hazard_state_t  : hazard sequencer states RUN / MEM_WAIT / FLUSH
//   REG_ZERO        : architectural zero register id (never a hazard source)
//   HAZ_*_DEF       : default FLUSH_CYCLES / MEM_TIMEOUT for hazard_unit
//   sat_inc8/sat_dec4 : saturating counter helpers
// -----------------------------------------------------------------------------
package common_pkg;

    localparam logic [4:0] REG_ZERO             = 5'd0;
    localparam int         HAZ_FLUSH_CYCLES_DEF = 2;
    localparam int         HAZ_MEM_TIMEOUT_DEF  = 15;

    typedef struct packed {
        logic [4:0] write_back_id;
        logic       mem_read;
    } control_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } hazard_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] sat_dec4(input logic [3:0] v);
        return (v == 4'd0) ? v : v - 4'd1;
    endfunction

endpackage

// File: rtl/hazard_unit_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use comparator: flags when the instruction in EX
// is a load whose destination is read by the instruction in ID.
// Ports:
//   rs_1_id_i, rs_2_id_i     : ID-stage source register ids
//   rs_1_used_i, rs_2_used_i : ID instruction actually reads that operand
//   control_ex_i             : EX-stage control (write_back_id, mem_read)
//   hazard_o                 : load-use hazard present
// -----------------------------------------------------------------------------
module load_use_detect
    import common_pkg::*;
(
    input  logic [4:0] rs_1_id_i,
    input  logic [4:0] rs_2_id_i,
    input  logic       rs_1_used_i,
    input  logic       rs_2_used_i,
    input  control_t   control_ex_i,
    output logic       hazard_o
);

    logic match_1;
    logic match_2;

    assign match_1 = rs_1_used_i && (rs_1_id_i == control_ex_i.write_back_id);
    assign match_2 = rs_2_used_i && (rs_2_id_i == control_ex_i.write_back_id);

    // x0 is hard-wired zero, so a load targeting it never feeds a consumer.
    assign hazard_o = control_ex_i.mem_read
                   && (control_ex_i.write_back_id != REG_ZERO)
                   && (match_1 || match_2);

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Stall/flush generator for the 5-stage pipeline: load-use bubbles, freezes
// while a data-memory load is outstanding, and squashes wrong-path
// instructions after a taken branch/jump resolved in EX.
// Parameters:
//   FLUSH_CYCLES (1..15)  : extra cycles flush_id is held after a redirect
//   MEM_TIMEOUT  (1..255) : max consecutive MEM_WAIT cycles before error
// Ports:
//   clk, rst (async, active-low)
//   rs_1_id, rs_2_id, rs_1_used, rs_2_used : ID-stage operand info
//   control_ex       : EX-stage control (write_back_id, mem_read)
//   branch_taken_ex  : EX resolved a taken branch/jump
//   mem_req, mem_ready : MEM load request / data return
//   stall_pc, stall_if_id, freeze_all : hold controls
//   flush_id, flush_ex : squash controls
//   mem_timeout      : sticky load-timeout error
// Optional (macro HAZARD_PERF_CNT_EN):
//   perf_load_use_cnt, perf_mem_wait_cnt, perf_flush_cnt : saturating
//   32-bit cycle counters of load-use bubbles, frozen cycles, flush_id cycles.
// -----------------------------------------------------------------------------
module hazard_unit
    import common_pkg::*;
#(
    parameter int FLUSH_CYCLES = HAZ_FLUSH_CYCLES_DEF,
    parameter int MEM_TIMEOUT  = HAZ_MEM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_1_id,
    input  logic [4:0]  rs_2_id,
    input  logic        rs_1_used,
    input  logic        rs_2_used,
    input  control_t    control_ex,
    input  logic        branch_taken_ex,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        freeze_all,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_load_use_cnt,
    output logic [31:0] perf_mem_wait_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam logic [3:0] FLUSH_INIT  = 4'(FLUSH_CYCLES);
    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    hazard_state_t state_q, state_d;
    logic [3:0]    flush_cnt_q, flush_cnt_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic          timeout_q, timeout_d;

    logic          lu_hit;
    logic          mem_miss;
    logic [7:0]    wait_inc;
    hazard_state_t resume_state;

    logic          stall_w;
    logic          freeze_w;
    logic          flush_id_w;
    logic          flush_ex_w;
    logic          lu_active_w;

    load_use_detect u_load_use_detect (
        .rs_1_id_i    (rs_1_id),
        .rs_2_id_i    (rs_2_id),
        .rs_1_used_i  (rs_1_used),
        .rs_2_used_i  (rs_2_used),
        .control_ex_i (control_ex),
        .hazard_o     (lu_hit)
    );

    assign mem_miss = mem_req && !mem_ready;
    assign wait_inc = sat_inc8(wait_cnt_q);
    // A flush interrupted by a load wait picks up where it left off.
    assign resume_state = (flush_cnt_q != 4'd0) ? FLUSH : RUN;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        stall_w     = 1'b0;
        freeze_w    = 1'b0;
        flush_id_w  = 1'b0;
        flush_ex_w  = 1'b0;
        lu_active_w = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_miss) begin
                    // The load is not back yet: hold the whole pipe now.
                    stall_w    = 1'b1;
                    freeze_w   = 1'b1;
                    wait_cnt_d = 8'd0;
                    state_d    = MEM_WAIT;
                end else if (branch_taken_ex) begin
                    flush_id_w  = 1'b1;
                    flush_ex_w  = 1'b1;
                    flush_cnt_d = FLUSH_INIT;
                    state_d     = FLUSH;
                end else if (lu_hit) begin
                    stall_w     = 1'b1;
                    flush_ex_w  = 1'b1;
                    lu_active_w = 1'b1;
                end
            end

            MEM_WAIT: begin
                // EX is frozen, so a branch seen here is re-presented later.
                stall_w    = 1'b1;
                freeze_w   = 1'b1;
                wait_cnt_d = wait_inc;
                if (mem_ready) begin
                    wait_cnt_d = 8'd0;
                    state_d    = resume_state;
                end else if (wait_inc >= TIMEOUT_LIM) begin
                    timeout_d  = 1'b1;
                    wait_cnt_d = 8'd0;
                    state_d    = resume_state;
                end
            end

            FLUSH: begin
                if (mem_miss) begin
                    stall_w    = 1'b1;
                    freeze_w   = 1'b1;
                    wait_cnt_d = 8'd0;
                    state_d    = MEM_WAIT;
                end else if (branch_taken_ex) begin
                    flush_id_w  = 1'b1;
                    flush_ex_w  = 1'b1;
                    flush_cnt_d = FLUSH_INIT;
                end else begin
                    flush_id_w  = 1'b1;
                    flush_cnt_d = sat_dec4(flush_cnt_q);
                    if (flush_cnt_q <= 4'd1) begin
                        state_d = RUN;
                    end
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            flush_cnt_q <= 4'd0;
            wait_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign stall_pc    = rst && stall_w;
    assign stall_if_id = rst && stall_w;
    assign freeze_all  = rst && freeze_w;
    assign flush_id    = rst && flush_id_w;
    assign flush_ex    = rst && flush_ex_w;
    assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_q;
    logic [31:0] perf_mw_q;
    logic [31:0] perf_fl_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_lu_q <= 32'd0;
            perf_mw_q <= 32'd0;
            perf_fl_q <= 32'd0;
        end else begin
            if (lu_active_w && (perf_lu_q != 32'hFFFF_FFFF)) perf_lu_q <= perf_lu_q + 32'd1;
            if (freeze_w    && (perf_mw_q != 32'hFFFF_FFFF)) perf_mw_q <= perf_mw_q + 32'd1;
            if (flush_id_w  && (perf_fl_q != 32'hFFFF_FFFF)) perf_fl_q <= perf_fl_q + 32'd1;
        end
    end

    assign perf_load_use_cnt = perf_lu_q;
    assign perf_mem_wait_cnt = perf_mw_q;
    assign perf_flush_cnt    = perf_fl_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
// Scoreboard bench for hazard_unit. The driver applies one input vector per
// cycle, evaluates a behavioural model of the stall/flush rules and queues the
// expected outputs; the monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_unit;
    import common_pkg::*;

    localparam int FC = HAZ_FLUSH_CYCLES_DEF;
    localparam int MT = HAZ_MEM_TIMEOUT_DEF;

    logic       clk;
    logic       rst;
    logic [4:0] rs_1_id, rs_2_id;
    logic       rs_1_used, rs_2_used;
    control_t   control_ex;
    logic       branch_taken_ex, mem_req, mem_ready;
    logic       stall_pc, stall_if_id, freeze_all, flush_id, flush_ex, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_load_use_cnt, perf_mem_wait_cnt, perf_flush_cnt;
`endif

    hazard_unit #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
        .clk             (clk),
        .rst             (rst),
        .rs_1_id         (rs_1_id),
        .rs_2_id         (rs_2_id),
        .rs_1_used       (rs_1_used),
        .rs_2_used       (rs_2_used),
        .control_ex      (control_ex),
        .branch_taken_ex (branch_taken_ex),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .stall_pc        (stall_pc),
        .stall_if_id     (stall_if_id),
        .freeze_all      (freeze_all),
        .flush_id        (flush_id),
        .flush_ex        (flush_ex),
        .mem_timeout     (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_load_use_cnt (perf_load_use_cnt),
        .perf_mem_wait_cnt (perf_mem_wait_cnt),
        .perf_flush_cnt    (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector order: stall_pc, stall_if_id, freeze_all, flush_id, flush_ex, mem_timeout
    typedef struct {
        logic [5:0] v;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Behavioural model: a load is either outstanding or not; squashing owes
    // a number of further flush_id cycles that a load wait merely postpones.
    bit m_loading;
    int m_waited;
    int m_flush_left;
    bit m_timed_out;

    task automatic model_reset();
        m_loading    = 1'b0;
        m_waited     = 0;
        m_flush_left = 0;
        m_timed_out  = 1'b0;
    endtask

    task automatic model_push(input string tag);
        exp_t e;
        bit   hold, frz, fid, fex, lu;
        hold = 0; frz = 0; fid = 0; fex = 0;
        if (!rst) begin
            model_reset();
            e.v = 6'b0;
        end else begin
            lu = control_ex.mem_read && (control_ex.write_back_id != 5'd0) &&
                 ((rs_1_used && rs_1_id == control_ex.write_back_id) ||
                  (rs_2_used && rs_2_id == control_ex.write_back_id));
            e.v[0] = m_timed_out;
            if (m_loading) begin
                hold = 1; frz = 1;
                m_waited = m_waited + 1;
                if (mem_ready) begin
                    m_loading = 0;
                end else if (m_waited >= MT) begin
                    m_loading   = 0;
                    m_timed_out = 1;
                end
            end else if (mem_req && !mem_ready) begin
                hold = 1; frz = 1;
                m_loading = 1;
                m_waited  = 0;
            end else if (branch_taken_ex) begin
                fid = 1; fex = 1;
                m_flush_left = FC;
            end else if (m_flush_left > 0) begin
                fid = 1;
                m_flush_left = m_flush_left - 1;
            end else if (lu) begin
                hold = 1; fex = 1;
            end
            e.v[5:1] = {hold, hold, frz, fid, fex};
        end
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input logic [4:0] a1, input bit u1,
                       input logic [4:0] a2, input bit u2, input logic [4:0] wb,
                       input bit mr, input bit br, input bit mq, input bit rdy,
                       input string tag);
        @(posedge clk);
        #1;
        rst                      = r;
        rs_1_id                  = a1;
        rs_1_used                = u1;
        rs_2_id                  = a2;
        rs_2_used                = u2;
        control_ex.write_back_id = wb;
        control_ex.mem_read      = mr;
        branch_taken_ex          = br;
        mem_req                  = mq;
        mem_ready                = rdy;
        model_push(tag);
    endtask

    task automatic idle(input string tag);
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, tag);
    endtask

    // Drop reset between clock edges and expect every output to fall at once.
    task automatic reset_mid(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        cyc_inputs_idle();
        #2;
        rst = 1'b0;
        model_reset();
        e.v   = 6'b0;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic cyc_inputs_idle();
        rs_1_id = 5'd0; rs_1_used = 0; rs_2_id = 5'd0; rs_2_used = 0;
        control_ex = '0; branch_taken_ex = 0; mem_req = 0; mem_ready = 0;
    endtask

    // Monitor: outputs are combinational, so every driven cycle presents one.
    always @(negedge clk) begin
        exp_t       e;
        logic [5:0] act;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {stall_pc, stall_if_id, freeze_all, flush_id, flush_ex, mem_timeout};
            n_checks++;
            if (act === e.v) n_pass++;
            else $display("FAIL %s: got %b want %b [stall_pc stall_if_id freeze_all flush_id flush_ex mem_timeout] t=%0t",
                          e.tag, act, e.v, $time);
        end
    end

    initial begin
        rst = 1'b0;
        cyc_inputs_idle();
        model_reset();

        cyc(0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 1, 0, "reset_hold");
        cyc(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, "reset_hold2");
        idle("after_reset");

        // Load-use
        cyc(1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0, "lu_rs1");
        cyc(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, "lu_bubble");
        cyc(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0, "lu_x0");
        cyc(1, 5'd3, 1, 5'd5, 0, 5'd5, 1, 0, 0, 0, "lu_unused_rs2");
        cyc(1, 5'd3, 1, 5'd5, 1, 5'd5, 1, 0, 0, 0, "lu_rs2");
        cyc(1, 5'd5, 1, 5'd5, 1, 5'd5, 0, 0, 0, 0, "lu_no_load");

        // Memory wait: ready low 3 cycles, high on the 4th
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, "mw_enter");
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, "mw_wait1");
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, "mw_wait2");
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, "mw_ready");
        idle("mw_after");
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, "zero_wait_load");

        // Branch flush with load-use presented during the flush
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, "br_detect");
        cyc(1, 5'd7, 1, 5'd0, 0, 5'd7, 1, 0, 0, 0, "br_flush1_lu");
        cyc(1, 5'd7, 1, 5'd0, 0, 5'd7, 1, 0, 0, 0, "br_flush2_lu");
        cyc(1, 5'd7, 1, 5'd0, 0, 5'd7, 1, 0, 0, 0, "br_done_lu");

        // Priority: branch with unmatched load waits first
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 0, "prio_mw_over_br");
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1, "prio_ready_br_ignored");
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, "prio_br_again");
        idle("prio_flush1");
        idle("prio_flush2");
        idle("prio_run");

        // Flush interrupted by a load wait, then resumed
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, "fi_detect");
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, "fi_mw_enter");
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, "fi_mw_ready");
        idle("fi_resume1");
        idle("fi_resume2");
        idle("fi_run");

        // Redirect chain inside FLUSH restarts the count
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, "chain_br1");
        idle("chain_f1");
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, "chain_br2");
        idle("chain_f2a");
        idle("chain_f2b");
        idle("chain_run");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 2) == 0), "rand");
        end
        idle("rand_tail");
        for (int i = 0; i < 20; i++) cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, "drain_ready");

        // Async reset in the middle of MEM_WAIT
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, "ar_mw_enter");
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, "ar_mw_wait");
        reset_mid("ar_async_reset");
        idle("ar_released");
        cyc(1, 5'd9, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0, "ar_run_lu");

        // Timeout: ready never comes back
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, "to_enter");
        for (int i = 0; i < MT + 4; i++) cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, "to_wait");
        cyc(1, 5'd4, 1, 5'd0, 0, 5'd4, 1, 0, 0, 0, "to_sticky_lu");
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, "to_sticky_br");
        idle("to_sticky_f1");
        idle("to_sticky_f2");
        reset_mid("to_reset_clears");
        idle("to_after_reset");

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
